layer_ringbuf_rdport: RTL and testbench

Prover-side read port for one layer's input-history ringbuffer set. On request from prover layer P_j, it snapshots the buffered input vector and its computation instance id. It checks that id against the id the prover expects, then streams the vector one field element per cycle over a valid/ready handshake. After a complete read it pulses the ringbuffer advance strobe, so the buffer is consumed at the rate the prover actually reads it.

---
 rtl/layer_ringbuf_rdport_pkg.sv | 21 ++
 rtl/layer_ringbuf_rdport_if.sv | 31 +++
 rtl/layer_ringbuf_rdport_vec_snapshot_reg.sv | 37 +++
 rtl/layer_ringbuf_rdport.sv | 118 +++++++++++
 tb/tb_layer_ringbuf_rdport.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_ringbuf_rdport_pkg.sv
// Shared types and constants for the layer input-history ringbuffer read port.
// F_NBITS mirrors the field arithmetic word width used by the prover datapath.
package layer_ringbuf_rdport_pkg;

   localparam int F_NBITS = 64;
   localparam int ID_W    = 32;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      STREAM,
      ERR,
      DONE
   } rd_state_t;

   // Word-index width: never narrower than one bit, even for a single-word layer.
   function automatic int iw_f(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/layer_ringbuf_rdport_if.sv
// Prover-facing request/stream bundle of the ringbuffer read port.
// The master is the prover layer; the slave is the read port.
interface layer_ringbuf_rdport_if #(parameter int ninputs = 8);
   import layer_ringbuf_rdport_pkg::*;

   localparam int IW = iw_f(ninputs);

   logic               req;
   logic [ID_W-1:0]    req_id;
   logic               req_rdy;
   logic               abort;
   logic               w_valid;
   logic               w_ready;
   logic [F_NBITS-1:0] w_data;
   logic [IW-1:0]      w_idx;
   logic               w_last;
   logic               done;
   logic               err;
   logic [ID_W-1:0]    err_id;

   modport master (
      output req, req_id, abort, w_ready,
      input  req_rdy, w_valid, w_data, w_idx, w_last, done, err, err_id
   );

   modport slave (
      input  req, req_id, abort, w_ready,
      output req_rdy, w_valid, w_data, w_idx, w_last, done, err, err_id
   );

endinterface

// File: rtl/layer_ringbuf_rdport_vec_snapshot_reg.sv
// Load-enabled bank of ninputs field words with synchronous clear and an
// indexed read mux; holds the vector the port streams out.
module layer_ringbuf_rdport_vec_snapshot_reg
   import layer_ringbuf_rdport_pkg::*;
#(
   parameter int ninputs = 8,
   parameter int IW      = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            load,
   input  logic [ninputs-1:0][F_NBITS-1:0] d,
   input  logic [IW-1:0]                   rd_idx,
   output logic [F_NBITS-1:0]              rd_data
);

   logic [ninputs-1:0][F_NBITS-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
      end else if (load) begin
         mem_q <= d;
      end
   end

   // Compare-based mux keeps the index width independent of ninputs being a power of two.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < ninputs; i++) begin
         if (rd_idx == IW'(i)) begin
            rd_data = mem_q[i];
         end
      end
   end

endmodule

// File: rtl/layer_ringbuf_rdport.sv
// Prover-side read port for one layer's input ringbuffer: snapshot, id check,
// word-serial stream, then one advance strobe per completed read.
module layer_ringbuf_rdport
   import layer_ringbuf_rdport_pkg::*;
#(
   parameter int ninputs   = 8,
   parameter int layer_num = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ninputs-1:0][F_NBITS-1:0] v_pl,
   input  logic [ID_W-1:0]                 id_pl,
   output logic                            buf_adv,
   layer_ringbuf_rdport_if.slave           pif
);

   localparam int            IW       = iw_f(ninputs);
   localparam logic [IW-1:0] LAST_IDX = IW'(ninputs - 1);

   if (ninputs < 1 || layer_num < 0) begin : g_param_check
      $error("layer_ringbuf_rdport: ninputs must be >= 1 and layer_num >= 0");
   end

   rd_state_t          state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [ID_W-1:0]    req_id_q, snap_id_q, err_id_q;
   logic               load;
   logic               mismatch;
   logic               streaming;
   logic               at_last;
   logic [F_NBITS-1:0] rd_word;

   layer_ringbuf_rdport_vec_snapshot_reg #(
      .ninputs (ninputs),
      .IW      (IW)
   ) u_snap (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .d       (v_pl),
      .rd_idx  (idx_q),
      .rd_data (rd_word)
   );

   assign mismatch  = (snap_id_q != req_id_q);
   assign streaming = (state_q == STREAM);
   assign at_last   = (idx_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         req_id_q  <= '0;
         snap_id_q <= '0;
         err_id_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (load) begin
            req_id_q  <= pif.req_id;
            snap_id_q <= id_pl;
         end
         // Captured on entry to ERR so err_id is already valid while err pulses.
         if (state_q == CHECK && !pif.abort && mismatch) begin
            err_id_q <= snap_id_q;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pif.req) begin
               load    = 1'b1;
               idx_d   = '0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            idx_d = '0;
            if (pif.abort)     state_d = IDLE;
            else if (mismatch) state_d = ERR;
            else               state_d = STREAM;
         end
         STREAM: begin
            // Abort beats a coincident final handshake: that word counts as unread.
            if (pif.abort) begin
               idx_d   = '0;
               state_d = IDLE;
            end else if (pif.w_ready) begin
               if (at_last) begin
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ERR:     state_d = IDLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign pif.req_rdy = (state_q == IDLE) && !rst;
   assign pif.w_valid = streaming;
   assign pif.w_data  = streaming ? rd_word : '0;
   assign pif.w_idx   = idx_q;
   assign pif.w_last  = streaming && at_last;
   assign pif.done    = (state_q == DONE);
   assign pif.err     = (state_q == ERR);
   assign pif.err_id  = err_id_q;
   assign buf_adv     = (state_q == DONE);

endmodule

// File: tb/tb_layer_ringbuf_rdport.sv
// Scoreboard bench for layer_ringbuf_rdport with a 4-word and a 1-word instance.
`timescale 1ns/1ps
module tb_layer_ringbuf_rdport;
   import layer_ringbuf_rdport_pkg::*;

   localparam int K_WORD = 0;
   localparam int K_ERR  = 1;
   localparam int K_DONE = 2;

   typedef struct {
      int          kind;
      logic [63:0] data;
      int          idx;
      bit          last;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nvec = 0;
   int   nmis = 0;
   exp_t q4[$];
   exp_t q1[$];

   logic [3:0][F_NBITS-1:0] v4;
   logic [ID_W-1:0]         id4;
   logic                    buf_adv4;
   logic [0:0][F_NBITS-1:0] v1;
   logic [ID_W-1:0]         id1;
   logic                    buf_adv1;

   logic [63:0] word_tbl [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
   bit          bp_pat  [10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

   layer_ringbuf_rdport_if #(.ninputs(4)) p4 ();
   layer_ringbuf_rdport_if #(.ninputs(1)) p1 ();

   layer_ringbuf_rdport #(.ninputs(4), .layer_num(0)) dut4 (
      .clk(clk), .rst(rst), .v_pl(v4), .id_pl(id4), .buf_adv(buf_adv4), .pif(p4)
   );
   layer_ringbuf_rdport #(.ninputs(1), .layer_num(1)) dut1 (
      .clk(clk), .rst(rst), .v_pl(v1), .id_pl(id1), .buf_adv(buf_adv1), .pif(p1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endfunction

   function automatic void unexpected(input string nm, input logic [63:0] got);
      nvec++;
      nmis++;
      $display("FAIL %s: got event with value 0x%0h expected none (cycle %0d)", nm, got, cyc);
   endfunction

   function automatic exp_t mk(input int kind, input logic [63:0] data, input int idx,
                               input bit last, input int c);
      exp_t e;
      e.kind = kind; e.data = data; e.idx = idx; e.last = last; e.cyc = c;
      return e;
   endfunction

   function automatic void push4_read(input int t);
      for (int i = 0; i < 4; i++) q4.push_back(mk(K_WORD, word_tbl[i], i, (i == 3), t + 2 + i));
      q4.push_back(mk(K_DONE, 64'h0, 0, 1'b0, t + 6));
   endfunction

   // Monitor for the 4-word instance
   logic       stall4 = 1'b0;
   logic [63:0] held4;
   logic [1:0]  heldidx4;
   always @(negedge clk) begin : mon4
      exp_t e;
      if (stall4) begin
         chk("w4_hold_valid", 64'(p4.w_valid), 64'd1);
         chk("w4_hold_data", p4.w_data, held4);
         chk("w4_hold_idx", 64'(p4.w_idx), 64'(heldidx4));
      end
      stall4   <= p4.w_valid && !p4.w_ready && !p4.abort && !rst;
      held4    <= p4.w_data;
      heldidx4 <= p4.w_idx;
      if (p4.w_valid && p4.w_ready && !p4.abort) begin
         if (q4.size() == 0) unexpected("w4_word", p4.w_data);
         else begin
            e = q4.pop_front();
            chk("w4_word_kind", 64'(K_WORD), 64'(e.kind));
            chk("w4_data", p4.w_data, e.data);
            chk("w4_idx", 64'(p4.w_idx), 64'(e.idx));
            chk("w4_last", 64'(p4.w_last), 64'(e.last));
            if (e.cyc >= 0) chk("w4_word_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (p4.err) begin
         if (q4.size() == 0) unexpected("w4_err", p4.err_id);
         else begin
            e = q4.pop_front();
            chk("w4_err_kind", 64'(K_ERR), 64'(e.kind));
            chk("w4_err_id", 64'(p4.err_id), e.data);
            chk("w4_err_cycle", 64'(cyc), 64'(e.cyc));
            chk("w4_err_no_valid", 64'(p4.w_valid), 64'd0);
         end
      end
      if (p4.done) begin
         if (q4.size() == 0) unexpected("w4_done", 64'(cyc));
         else begin
            e = q4.pop_front();
            chk("w4_done_kind", 64'(K_DONE), 64'(e.kind));
            chk("w4_done_cycle", 64'(cyc), 64'(e.cyc));
            chk("w4_done_no_valid", 64'(p4.w_valid), 64'd0);
         end
      end
      if (buf_adv4 || p4.done) chk("w4_bufadv_with_done", 64'(buf_adv4), 64'(p4.done));
   end

   // Monitor for the 1-word instance
   always @(negedge clk) begin : mon1
      exp_t e;
      if (p1.w_valid && p1.w_ready && !p1.abort) begin
         if (q1.size() == 0) unexpected("w1_word", p1.w_data);
         else begin
            e = q1.pop_front();
            chk("w1_word_kind", 64'(K_WORD), 64'(e.kind));
            chk("w1_data", p1.w_data, e.data);
            chk("w1_idx", 64'(p1.w_idx), 64'(e.idx));
            chk("w1_last", 64'(p1.w_last), 64'(e.last));
            chk("w1_word_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (p1.err) unexpected("w1_err", p1.err_id);
      if (p1.done) begin
         if (q1.size() == 0) unexpected("w1_done", 64'(cyc));
         else begin
            e = q1.pop_front();
            chk("w1_done_kind", 64'(K_DONE), 64'(e.kind));
            chk("w1_done_cycle", 64'(cyc), 64'(e.cyc));
            chk("w1_idx_at_done", 64'(p1.w_idx), 64'd0);
         end
      end
      if (buf_adv1 || p1.done) chk("w1_bufadv_with_done", 64'(buf_adv1), 64'(p1.done));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic issue4(input logic [31:0] rid, output int t);
      p4.req = 1'b1; p4.req_id = rid; t = cyc;
      tick();
      p4.req = 1'b0;
   endtask

   task automatic check_idle4(input string tag);
      chk({tag, "_w_valid"}, 64'(p4.w_valid), 64'd0);
      chk({tag, "_w_data"}, p4.w_data, 64'd0);
      chk({tag, "_w_idx"}, 64'(p4.w_idx), 64'd0);
      chk({tag, "_w_last"}, 64'(p4.w_last), 64'd0);
      chk({tag, "_done"}, 64'(p4.done), 64'd0);
      chk({tag, "_buf_adv"}, 64'(buf_adv4), 64'd0);
      chk({tag, "_err"}, 64'(p4.err), 64'd0);
      chk({tag, "_err_id"}, 64'(p4.err_id), 64'd0);
   endtask

   initial begin : stim
      int t;
      p4.req = 1'b0; p4.req_id = '0; p4.abort = 1'b0; p4.w_ready = 1'b1;
      p1.req = 1'b0; p1.req_id = '0; p1.abort = 1'b0; p1.w_ready = 1'b1;
      v4 = '0; id4 = '0; v1 = '0; id1 = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle4("rst");
      chk("rst_req_rdy4", 64'(p4.req_rdy), 64'd0);
      chk("rst_req_rdy1", 64'(p1.req_rdy), 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_req_rdy4", 64'(p4.req_rdy), 64'd1);

      // nominal read
      tick();
      v4 = {64'h44, 64'h33, 64'h22, 64'h11};
      id4 = 32'd7;
      issue4(32'd7, t);
      push4_read(t);
      to_neg(t + 6);
      chk("nom_rdy_at_done", 64'(p4.req_rdy), 64'd0);
      to_neg(t + 7);
      chk("nom_rdy_back", 64'(p4.req_rdy), 64'd1);

      // id mismatch
      tick();
      id4 = 32'd5;
      issue4(32'd6, t);
      q4.push_back(mk(K_ERR, 64'd5, 0, 1'b0, t + 2));
      to_neg(t + 2);
      chk("mis_rdy_in_err", 64'(p4.req_rdy), 64'd0);
      to_neg(t + 3);
      chk("mis_rdy_back", 64'(p4.req_rdy), 64'd1);

      // backpressure
      tick();
      id4 = 32'd7;
      issue4(32'd7, t);
      q4.push_back(mk(K_WORD, 64'h11, 0, 1'b0, t + 2));
      q4.push_back(mk(K_WORD, 64'h22, 1, 1'b0, t + 5));
      q4.push_back(mk(K_WORD, 64'h33, 2, 1'b0, t + 8));
      q4.push_back(mk(K_WORD, 64'h44, 3, 1'b1, t + 11));
      q4.push_back(mk(K_DONE, 64'h0, 0, 1'b0, t + 12));
      for (int k = 0; k < 10; k++) begin
         tick();
         p4.w_ready = bp_pat[k];
      end
      tick();
      p4.w_ready = 1'b1;
      to_neg(t + 13);
      chk("bp_rdy_back", 64'(p4.req_rdy), 64'd1);

      // abort on the word-2 handshake, then re-read
      tick();
      issue4(32'd7, t);
      q4.push_back(mk(K_WORD, 64'h11, 0, 1'b0, t + 2));
      q4.push_back(mk(K_WORD, 64'h22, 1, 1'b0, t + 3));
      tick(); tick(); tick();
      p4.abort = 1'b1;
      tick();
      p4.abort = 1'b0;
      to_neg(t + 5);
      chk("abort_idle_rdy", 64'(p4.req_rdy), 64'd1);
      chk("abort_no_valid", 64'(p4.w_valid), 64'd0);
      tick();
      issue4(32'd7, t);
      push4_read(t);
      to_neg(t + 7);
      chk("reread_rdy_back", 64'(p4.req_rdy), 64'd1);

      // snapshot isolation and ignored busy req
      tick();
      issue4(32'd7, t);
      v4 = {4{64'hFF}};
      id4 = 32'd99;
      push4_read(t);
      tick(); tick();
      p4.req = 1'b1; p4.req_id = 32'd7;
      @(negedge clk);
      chk("busy_req_rdy", 64'(p4.req_rdy), 64'd0);
      tick();
      p4.req = 1'b0;
      to_neg(t + 7);
      chk("iso_rdy_back", 64'(p4.req_rdy), 64'd1);
      to_neg(t + 9);
      chk("iso_no_second_read", 64'(p4.w_valid), 64'd0);
      v4 = {64'h44, 64'h33, 64'h22, 64'h11};
      id4 = 32'd7;

      // reset mid-stream, then the same instance is read again
      tick();
      issue4(32'd7, t);
      q4.push_back(mk(K_WORD, 64'h11, 0, 1'b0, t + 2));
      q4.push_back(mk(K_WORD, 64'h22, 1, 1'b0, t + 3));
      tick(); tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_req_rdy1_held", 64'(p1.req_rdy), 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_idle4("midrst");
      chk("midrst_rdy", 64'(p4.req_rdy), 64'd1);
      tick();
      issue4(32'd7, t);
      push4_read(t);
      to_neg(t + 7);

      // single-word layer
      tick();
      v1[0] = 64'hAB;
      id1 = 32'd3;
      p1.req = 1'b1; p1.req_id = 32'd3; t = cyc;
      tick();
      p1.req = 1'b0;
      q1.push_back(mk(K_WORD, 64'hAB, 0, 1'b1, t + 2));
      q1.push_back(mk(K_DONE, 64'h0, 0, 1'b0, t + 3));
      to_neg(t + 3);
      chk("n1_rdy_at_done", 64'(p1.req_rdy), 64'd0);
      to_neg(t + 4);
      chk("n1_rdy_back", 64'(p1.req_rdy), 64'd1);

      repeat (4) @(negedge clk);
      chk("q4_drained", 64'(q4.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no finish by cycle %0d expected finish within budget", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
